pic_core_param: RTL and testbench

- Parametrised successor to the 8259A-style PIC: NUM_IRQ request lines with a mask register (IMR), a request register (IRR) and an in-service register (ISR).
- Fully nested priority, with optional rotating priority. Edge or level triggering. Single-cycle acknowledge/vector handshake.
- Sits between peripheral interrupt sources and the CPU core; programmed over a simple synchronous register bus instead of the 8259 CS/RD/WR/A0 bus.

---
 rtl/pic_core_param.sv | 219 +++++++++++++++++++++
 tb/tb_pic_core_param.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_core_param.sv
// Parametrised 8259A-style interrupt controller: IMR/IRR/ISR, nested or rotating priority, edge/level triggering.
// Optional automatic EOI is built in when the macro PIC_AEOI_EN is defined.
module pic_core_param #(
    parameter int          NUM_IRQ  = 8,
    parameter int          DATA_W   = 32,
    parameter logic [7:0]  VEC_BASE = 8'h20,
    parameter int          ID_W     = $clog2(NUM_IRQ)
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [1:0]         addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               int_o,
    input  logic               inta,
    output logic [7:0]         vector_o,
    output logic               vector_valid,
    output logic               spurious_o
);

    logic [NUM_IRQ-1:0] imr_q, imr_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [ID_W-1:0]    rot_ptr_q, rot_ptr_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               int_q, int_d;
    logic [7:0]         vector_q, vector_d;
    logic               vector_valid_q, vector_valid_d;
    logic               spurious_q, spurious_d;

    int                 pend_rank_s;
    int                 isr_rank_s;
    logic               ack_hit_s;
    logic [ID_W-1:0]    ack_id_s;
    logic [ID_W-1:0]    eoi_id_s;
    logic [ID_W-1:0]    spec_id_s;
    logic               unused_wdata_s;

    assign unused_wdata_s = ^wdata;

    // Distance of line i from the current top-priority line; 0 is highest.
    function automatic int rank_of(input int i, input int p);
        return (i >= p) ? (i - p) : (i + NUM_IRQ - p);
    endfunction

    // Best (smallest) rank among the set bits of m, NUM_IRQ when m is empty.
    function automatic int best_rank(input logic [NUM_IRQ-1:0] m, input int p);
        int r;
        r = NUM_IRQ;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (m[i] && (rank_of(i, p) < r)) begin
                r = rank_of(i, p);
            end
        end
        return r;
    endfunction

    function automatic logic [ID_W-1:0] rank_to_id(input int r, input int p);
        int j;
        j = r + p;
        if (j >= NUM_IRQ) begin
            j = j - NUM_IRQ;
        end
        return ID_W'(j);
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
        return ((int'(id) + 1) >= NUM_IRQ) ? {ID_W{1'b0}} : ID_W'(int'(id) + 1);
    endfunction

    // Arbitration on the current state: the ack winner and the non-specific EOI target.
    always_comb begin
        pend_rank_s = best_rank(irr_q & ~imr_q, int'(rot_ptr_q));
        isr_rank_s  = best_rank(isr_q, int'(rot_ptr_q));
        ack_hit_s   = (pend_rank_s < isr_rank_s);
        ack_id_s    = rank_to_id(pend_rank_s, int'(rot_ptr_q));
        eoi_id_s    = rank_to_id(isr_rank_s, int'(rot_ptr_q));
        spec_id_s   = wdata[ID_W-1:0];
    end

    // Next-state logic: register bus, EOI, acknowledge and request capture, in that precedence.
    always_comb begin
        imr_d          = imr_q;
        ctrl_d         = ctrl_q;
        isr_d          = isr_q;
        rot_ptr_d      = rot_ptr_q;
        irq_prev_d     = irq_i;
        irr_d          = ctrl_q[0] ? irq_i : irr_q;
        rdata_d        = rdata_q;
        vector_d       = vector_q;
        vector_valid_d = 1'b0;
        spurious_d     = 1'b0;

        if (rd_en) begin
            case (addr)
                2'd0:    rdata_d = DATA_W'(imr_q);
                2'd1:    rdata_d = DATA_W'(ctrl_q);
                2'd2:    rdata_d = DATA_W'(isr_q);
                2'd3:    rdata_d = DATA_W'(irr_q);
                default: rdata_d = {DATA_W{1'b0}};
            endcase
        end else begin
            rdata_d = rdata_q;
        end

        if (wr_en) begin
            case (addr)
                2'd0: imr_d = wdata[NUM_IRQ-1:0];
`ifdef PIC_AEOI_EN
                2'd1: ctrl_d = wdata[2:0];
`else
                2'd1: ctrl_d = {1'b0, wdata[1:0]};
`endif
                2'd2: begin
                    if (isr_q == {NUM_IRQ{1'b0}}) begin
                        isr_d = isr_q;
                    end else if (wdata[DATA_W-1]) begin
                        if (int'(spec_id_s) < NUM_IRQ) begin
                            isr_d[spec_id_s] = 1'b0;
                            if (ctrl_q[1] && wdata[DATA_W-2]) begin
                                rot_ptr_d = next_ptr(spec_id_s);
                            end
                        end else begin
                            isr_d = isr_q;
                        end
                    end else begin
                        isr_d[eoi_id_s] = 1'b0;
                        if (ctrl_q[1]) begin
                            rot_ptr_d = next_ptr(eoi_id_s);
                        end
                    end
                end
                default: imr_d = imr_q;
            endcase
        end else begin
            imr_d = imr_q;
        end

        // The acknowledge sees pre-write IMR and pre-EOI ISR, but its ISR set lands after the EOI clear.
        if (inta) begin
            vector_valid_d = 1'b1;
            if (ack_hit_s) begin
                vector_d = VEC_BASE + 8'(ack_id_s);
`ifdef PIC_AEOI_EN
                if (ctrl_q[2]) begin
                    if (ctrl_q[1]) begin
                        rot_ptr_d = next_ptr(ack_id_s);
                    end
                end else begin
                    isr_d[ack_id_s] = 1'b1;
                end
`else
                isr_d[ack_id_s] = 1'b1;
`endif
                if (!ctrl_q[0]) begin
                    irr_d[ack_id_s] = 1'b0;
                end
            end else begin
                spurious_d = 1'b1;
                vector_d   = VEC_BASE + 8'(NUM_IRQ - 1);
            end
        end else begin
            vector_valid_d = 1'b0;
        end

        // A new edge is merged last so it survives an ack clearing the same bit.
        if (!ctrl_q[0]) begin
            irr_d = irr_d | (irq_i & ~irq_prev_q);
        end else begin
            irr_d = irq_i;
        end
    end

    // Interrupt request evaluated on the state that will be registered this cycle.
    always_comb begin
        int_d = (best_rank(irr_d & ~imr_d, int'(rot_ptr_d)) < best_rank(isr_d, int'(rot_ptr_d)));
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            imr_q          <= {NUM_IRQ{1'b1}};
            irr_q          <= {NUM_IRQ{1'b0}};
            isr_q          <= {NUM_IRQ{1'b0}};
            irq_prev_q     <= {NUM_IRQ{1'b0}};
            ctrl_q         <= 3'b000;
            rot_ptr_q      <= {ID_W{1'b0}};
            rdata_q        <= {DATA_W{1'b0}};
            int_q          <= 1'b0;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
            spurious_q     <= 1'b0;
        end else begin
            imr_q          <= imr_d;
            irr_q          <= irr_d;
            isr_q          <= isr_d;
            irq_prev_q     <= irq_prev_d;
            ctrl_q         <= ctrl_d;
            rot_ptr_q      <= rot_ptr_d;
            rdata_q        <= rdata_d;
            int_q          <= int_d;
            vector_q       <= vector_d;
            vector_valid_q <= vector_valid_d;
            spurious_q     <= spurious_d;
        end
    end

    assign rdata        = rdata_q;
    assign int_o        = int_q;
    assign vector_o     = vector_q;
    assign vector_valid = vector_valid_q;
    assign spurious_o   = spurious_q;

endmodule

// File: tb/tb_pic_core_param.sv
// Directed bench for pic_core_param with a per-cycle reference model and literal spot checks.
module tb_pic_core_param;

    localparam int         N  = 8;
    localparam int         DW = 32;
    localparam logic [7:0] VB = 8'h20;

    logic          CLK;
    logic          RST_N;
    logic [N-1:0]  irq_i;
    logic          wr_en, rd_en, inta;
    logic [1:0]    addr;
    logic [DW-1:0] wdata, rdata;
    logic          int_o, vector_valid, spurious_o;
    logic [7:0]    vector_o;

    int            checks = 0;
    int            errors = 0;
    logic [N-1:0]  irq_hold = 8'h00;

    // Reference model state (reset values)
    logic [N-1:0]  m_imr = 8'hFF, m_irr = 8'h00, m_isr = 8'h00, m_prev = 8'h00;
    logic [2:0]    m_ctrl = 3'b000;
    int            m_ptr = 0;
    logic          m_int = 1'b0, m_vv = 1'b0, m_sp = 1'b0;
    logic [7:0]    m_vec = 8'h00;
    logic [DW-1:0] m_rdata = 32'h0;

    pic_core_param #(.NUM_IRQ(N), .DATA_W(DW), .VEC_BASE(VB)) dut (
        .CLK(CLK), .RST_N(RST_N), .irq_i(irq_i), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .int_o(int_o), .inta(inta),
        .vector_o(vector_o), .vector_valid(vector_valid), .spurious_o(spurious_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int rnk(input int i, input int p);
        return (i - p + N) % N;
    endfunction

    function automatic int best_id(input logic [N-1:0] m, input int p);
        int b = -1;
        for (int i = 0; i < N; i++)
            if (m[i] && (b < 0 || rnk(i, p) < rnk(b, p))) b = i;
        return b;
    endfunction

    // Highest-priority unmasked request not blocked by an in-service line, or -1
    function automatic int winner(input logic [N-1:0] irr, input logic [N-1:0] imr,
                                  input logic [N-1:0] isr, input int p);
        int w = best_id(irr & ~imr, p);
        int s = best_id(isr, p);
        if (w >= 0 && s >= 0 && rnk(w, p) >= rnk(s, p)) w = -1;
        return w;
    endfunction

    task automatic model_step(input logic rst, input logic [N-1:0] iv, input logic we,
                              input logic re, input logic [1:0] a, input logic [DW-1:0] d,
                              input logic ia);
        logic [N-1:0] o_isr;
        logic [2:0]   o_ctrl;
        int           w, id;
        if (!rst) begin
            m_imr = 8'hFF; m_irr = 8'h00; m_isr = 8'h00; m_prev = 8'h00; m_ctrl = 3'b000;
            m_ptr = 0; m_int = 1'b0; m_vv = 1'b0; m_sp = 1'b0; m_vec = 8'h00; m_rdata = 32'h0;
            return;
        end
        o_isr  = m_isr;
        o_ctrl = m_ctrl;
        w      = winner(m_irr, m_imr, m_isr, m_ptr);
        m_vv   = 1'b0;
        m_sp   = 1'b0;
        if (re) begin
            case (a)
                2'd0:    m_rdata = 32'(m_imr);
                2'd1:    m_rdata = 32'(m_ctrl);
                2'd2:    m_rdata = 32'(m_isr);
                default: m_rdata = 32'(m_irr);
            endcase
        end
        if (o_ctrl[0]) m_irr = iv;
        if (we) begin
            if (a == 2'd0) m_imr = d[N-1:0];
`ifdef PIC_AEOI_EN
            if (a == 2'd1) m_ctrl = d[2:0];
`else
            if (a == 2'd1) m_ctrl = {1'b0, d[1:0]};
`endif
            if (a == 2'd2 && o_isr != 8'h00) begin
                if (d[31]) begin
                    id = int'(d[2:0]);
                    m_isr[id] = 1'b0;
                    if (o_ctrl[1] && d[30]) m_ptr = (id + 1) % N;
                end else begin
                    id = best_id(o_isr, m_ptr);
                    m_isr[id] = 1'b0;
                    if (o_ctrl[1]) m_ptr = (id + 1) % N;
                end
            end
        end
        if (ia) begin
            m_vv = 1'b1;
            if (w >= 0) begin
                m_vec = VB + 8'(w);
                if (o_ctrl[2]) begin
                    if (o_ctrl[1]) m_ptr = (w + 1) % N;
                end else begin
                    m_isr[w] = 1'b1;
                end
                if (!o_ctrl[0]) m_irr[w] = 1'b0;
            end else begin
                m_sp  = 1'b1;
                m_vec = VB + 8'(N - 1);
            end
        end
        if (!o_ctrl[0]) m_irr = m_irr | (iv & ~m_prev);
        m_prev = iv;
        m_int  = (winner(m_irr, m_imr, m_isr, m_ptr) >= 0);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("int_o",        32'(int_o),        32'(m_int));
        cmp("vector_valid", 32'(vector_valid), 32'(m_vv));
        cmp("spurious_o",   32'(spurious_o),   32'(m_sp));
        cmp("vector_o",     32'(vector_o),     32'(m_vec));
        cmp("rdata",        rdata,             m_rdata);
    endtask

    // One clock: compare the outputs of the previous edge, then drive and advance the model
    task automatic cyc(input logic rst, input logic [N-1:0] iv, input logic we, input logic re,
                       input logic [1:0] a, input logic [DW-1:0] d, input logic ia);
        @(negedge CLK);
        check_all();
        RST_N = rst; irq_i = iv; wr_en = we; rd_en = re; addr = a; wdata = d; inta = ia;
        model_step(rst, iv, we, re, a, d, ia);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, irq_hold, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [DW-1:0] d);
        cyc(1'b1, irq_hold, 1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic pulse(input logic [N-1:0] v);
        cyc(1'b1, v, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        idle(1);
    endtask

    task automatic rd_lit(input string nm, input logic [1:0] a, input logic [31:0] exp);
        cyc(1'b1, irq_hold, 1'b0, 1'b1, a, 32'h0, 1'b0);
        idle(1);
        cmp(nm, rdata, exp);
    endtask

    task automatic ack_lit(input string nm, input logic [7:0] vec, input logic sp);
        cyc(1'b1, irq_hold, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        idle(1);
        cmp({nm, "_valid"}, 32'(vector_valid), 32'h1);
        cmp({nm, "_vec"},   32'(vector_o),     32'(vec));
        cmp({nm, "_spur"},  32'(spurious_o),   32'(sp));
    endtask

    initial begin
        RST_N = 1'b0; irq_i = 8'h00; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wdata = 32'h0; inta = 1'b0;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
        cmp("rst_int", 32'(int_o), 32'h0);
        cmp("rst_vec", 32'(vector_o), 32'h0);
        cmp("rst_rdata", rdata, 32'h0);
        idle(1);
        rd_lit("rst_imr", 2'd0, 32'h0000_00FF);

        // Edge mode, IRQ3 then IRQ1 pending
        wr(2'd0, 32'h0);
        pulse(8'h08);
        pulse(8'h02);
        cmp("int_pending", 32'(int_o), 32'h1);
        ack_lit("ack1", 8'h21, 1'b0);
        rd_lit("isr_after_ack1", 2'd2, 32'h02);
        rd_lit("irr_after_ack1", 2'd3, 32'h08);
        wr(2'd2, 32'h0);
        rd_lit("isr_after_eoi", 2'd2, 32'h00);
        ack_lit("ack3", 8'h23, 1'b0);
        wr(2'd2, 32'h0);

        // Rotating priority
        wr(2'd1, 32'h2);
        pulse(8'h21);
        ack_lit("rot_ack0", 8'h20, 1'b0);
        wr(2'd2, 32'h0);
        pulse(8'h01);
        ack_lit("rot_ack5", 8'h25, 1'b0);
        wr(2'd2, 32'h0);
        ack_lit("rot_ack0b", 8'h20, 1'b0);
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h0);

        // Level mode with IRQ2 held
        wr(2'd1, 32'h1);
        irq_hold = 8'h04;
        idle(2);
        ack_lit("lvl_ack", 8'h22, 1'b0);
        cmp("lvl_blocked", 32'(int_o), 32'h0);
        wr(2'd2, 32'h0);
        idle(1);
        cmp("lvl_reassert", 32'(int_o), 32'h1);
        irq_hold = 8'h00;
        idle(2);
        cmp("lvl_drop_int", 32'(int_o), 32'h0);
        rd_lit("lvl_irr", 2'd3, 32'h0);

        // Reset with acknowledge held aborts it
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        idle(2);
        cmp("rst_abort_valid", 32'(vector_valid), 32'h0);

        // Nesting
        wr(2'd0, 32'h0);
        pulse(8'h10);
        ack_lit("nest_ack4", 8'h24, 1'b0);
        pulse(8'h40);
        idle(1);
        cmp("nest_block6", 32'(int_o), 32'h0);
        pulse(8'h04);
        cmp("nest_allow2", 32'(int_o), 32'h1);
        ack_lit("nest_ack2", 8'h22, 1'b0);
        wr(2'd2, 32'h0);
        wr(2'd2, 32'h8000_0004);
        rd_lit("spec_eoi_isr", 2'd2, 32'h0);

        // IMR write coincident with the acknowledge uses the old mask
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0000_00FF, 1'b1);
        idle(1);
        cmp("imr_race_vec", 32'(vector_o), 32'h26);
        wr(2'd2, 32'h0);
        pulse(8'h01);
        ack_lit("spur", 8'h27, 1'b1);
        rd_lit("spur_isr", 2'd2, 32'h0);

        // Read and write together return the pre-write value
        cyc(1'b1, 8'h00, 1'b1, 1'b1, 2'd0, 32'h0, 1'b0);
        idle(1);
        cmp("rdwr_old", rdata, 32'hFF);
        ack_lit("masked_capture", 8'h20, 1'b0);
        wr(2'd2, 32'h0);

        // EOI coincident with the acknowledge
        pulse(8'h08);
        ack_lit("eoi_race_pre", 8'h23, 1'b0);
        pulse(8'h02);
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 2'd2, 32'h0, 1'b1);
        idle(1);
        cmp("eoi_race_vec", 32'(vector_o), 32'h21);
        rd_lit("eoi_race_isr", 2'd2, 32'h02);
        wr(2'd2, 32'h0);

        // Automatic EOI control bit
        wr(2'd1, 32'h4);
`ifdef PIC_AEOI_EN
        rd_lit("aeoi_ctrl", 2'd1, 32'h4);
        pulse(8'h20);
        ack_lit("aeoi_ack", 8'h25, 1'b0);
        rd_lit("aeoi_isr", 2'd2, 32'h0);
`else
        rd_lit("aeoi_ctrl_ro", 2'd1, 32'h0);
        pulse(8'h20);
        ack_lit("noaeoi_ack", 8'h25, 1'b0);
        rd_lit("noaeoi_isr", 2'd2, 32'h20);
`endif
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
